// File: rtl/dctq_pkg.sv
// Shared DCTQ datapath constants and sequencer state encodings.
package dctq_pkg;
  localparam int DCTQ_ROWS   = 8;
  localparam int DCTQ_WORD_W = 64;
  localparam int DCTQ_ADDR_W = 3;

  typedef enum logic {WFILL, WFULL} wr_state_t;
  typedef enum logic {RIDLE, RDRAIN} rd_state_t;
endpackage

// File: rtl/dualram_seq_rd_valid_pipe.sv
// Delay line carrying {issue, first, last} flags alongside the dualram read latency.
module rd_valid_pipe #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] flags_in,
  output logic [2:0] flags_out
);

  logic [2:0] flags_p [STAGES];

  // Shift flags one stage per cycle; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) flags_p[i] <= '0;
    end else begin
      flags_p[0] <= flags_in;
      for (int i = 1; i < STAGES; i++) flags_p[i] <= flags_p[i-1];
    end
  end

  assign flags_out = flags_p[STAGES-1];

endmodule

// File: rtl/dualram_seq.sv
// Write/read sequencer for the dualram ping-pong transpose memory.
module dualram_seq
  import dctq_pkg::*;
#(
  parameter int ROWS   = DCTQ_ROWS,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DCTQ_WORD_W-1:0]   in_data,
  output logic [DCTQ_WORD_W-1:0]   ram_di,
  output logic                     ram_din_valid,
  output logic [DCTQ_WORD_W/8-1:0] ram_be,
  output logic [DCTQ_ADDR_W-1:0]   ram_wa,
  output logic [DCTQ_ADDR_W-1:0]   ram_ra,
  output logic                     ram_rnw,
  input  logic [DCTQ_WORD_W-1:0]   ram_do,
  output logic                     out_valid,
  output logic [DCTQ_WORD_W-1:0]   out_data,
  output logic                     out_first,
  output logic                     out_last
);

  localparam logic [DCTQ_ADDR_W-1:0] LAST_IDX = DCTQ_ADDR_W'(ROWS - 1);

  wr_state_t                wr_state, wr_state_n;
  rd_state_t                rd_state, rd_state_n;
  logic [DCTQ_ADDR_W-1:0]   wcnt, wcnt_n;
  logic [DCTQ_ADDR_W-1:0]   rcnt, rcnt_n;
  logic                     rnw_n;
  logic                     wr_fire;
  logic                     rd_issue;
  logic                     swap;
  logic [2:0]               flags_in;
  logic [2:0]               flags_out;

  // in_ready is a pure function of state (and held low while in reset).
  assign in_ready      = (wr_state == WFILL) && !rst;
  assign wr_fire       = in_valid && in_ready;
  assign rd_issue      = (rd_state == RDRAIN);
  assign swap          = (wr_state == WFULL) && (rd_state == RIDLE);

  assign ram_di        = in_data;
  assign ram_din_valid = wr_fire;
  assign ram_be        = {(DCTQ_WORD_W/8){wr_fire}};
  assign ram_wa        = wcnt;
  assign ram_ra        = rcnt;
  assign out_data      = ram_do;

  // State, counter and bank-select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WFILL;
      rd_state <= RIDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      ram_rnw  <= 1'b1;
    end else begin
      wr_state <= wr_state_n;
      rd_state <= rd_state_n;
      wcnt     <= wcnt_n;
      rcnt     <= rcnt_n;
      ram_rnw  <= rnw_n;
    end
  end

  // Next-state: fill rows, drain columns, and swap banks once both sides are done.
  always_comb begin
    wr_state_n = wr_state;
    rd_state_n = rd_state;
    wcnt_n     = wcnt;
    rcnt_n     = rcnt;
    rnw_n      = ram_rnw;
    if (wr_fire) begin
      if (wcnt == LAST_IDX) begin
        wcnt_n     = '0;
        wr_state_n = WFULL;
      end else begin
        wcnt_n = wcnt + 1'b1;
      end
    end
    if (rd_issue) begin
      if (rcnt == LAST_IDX) begin
        rcnt_n     = '0;
        rd_state_n = RIDLE;
      end else begin
        rcnt_n = rcnt + 1'b1;
      end
    end
    if (swap) begin
      rnw_n      = ~ram_rnw;
      wr_state_n = WFILL;
      rd_state_n = RDRAIN;
    end
  end

  // Column flags for this issue; they emerge aligned with ram_do.
  assign flags_in = {rd_issue, rd_issue && (rcnt == '0), rd_issue && (rcnt == LAST_IDX)};

  rd_valid_pipe #(
    .STAGES (RD_LAT)
  ) u_rd_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .flags_in  (flags_in),
    .flags_out (flags_out)
  );

  assign out_valid = flags_out[2];
  assign out_first = flags_out[1];
  assign out_last  = flags_out[0];

endmodule

// File: tb/tb_dualram_seq.sv
// Scoreboard bench for dualram_seq with a behavioural dualram transpose memory.
module tb_dualram_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b1;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [63:0] ram_di;
  logic        ram_din_valid;
  logic [7:0]  ram_be;
  logic [2:0]  ram_wa;
  logic [2:0]  ram_ra;
  logic        ram_rnw;
  logic [63:0] ram_do;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_first;
  logic        out_last;

  dualram_seq #(.ROWS(8), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ram_di(ram_di), .ram_din_valid(ram_din_valid), .ram_be(ram_be), .ram_wa(ram_wa),
    .ram_ra(ram_ra), .ram_rnw(ram_rnw), .ram_do(ram_do), .out_valid(out_valid),
    .out_data(out_data), .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural dualram: rnw=1 writes bank 0 and reads bank 1; read is
  // a transpose (column c = byte c of every row), registered twice.
  logic [63:0] bank [2][8];
  logic [2:0]  ra_q;
  logic        rb_q;
  logic [63:0] do_q;
  logic [63:0] be_mask;
  always_comb for (int k = 0; k < 8; k++) be_mask[8*k +: 8] = {8{ram_be[k]}};
  always @(posedge clk) begin
    if (ram_din_valid)
      bank[!ram_rnw][ram_wa] <= (bank[!ram_rnw][ram_wa] & ~be_mask) | (ram_di & be_mask);
    ra_q <= ram_ra;
    rb_q <= ram_rnw;
    for (int r = 0; r < 8; r++) do_q[8*r +: 8] <= bank[rb_q][r][{ra_q, 3'b000} +: 8];
  end
  assign ram_do = do_q;

  typedef struct {
    logic [63:0] data;
    logic        first;
    logic        last;
  } exp_t;
  exp_t sb[$];

  // kind 0: every byte of row r equals r. kind 1: byte c of row r = {b, r, c}.
  function automatic logic [63:0] row_word(input int kind, input int b, input int r);
    logic [63:0] w;
    for (int c = 0; c < 8; c++)
      w[8*c +: 8] = (kind == 0) ? 8'(r) : {2'(b), 3'(r), 3'(c)};
    return w;
  endfunction

  function automatic logic [63:0] col_word(input int kind, input int b, input int c);
    logic [63:0] w;
    if (kind == 0) w = 64'h0706050403020100;
    else for (int r = 0; r < 8; r++) w[8*r +: 8] = {2'(b), 3'(r), 3'(c)};
    return w;
  endfunction

  // Monitor: pops and compares on every out_valid, tracks gaps and bank toggles.
  int  first_out_cyc = 0;
  int  ncols = 0;
  logic prev_ov = 1'b0;
  logic prev_rnw = 1'b1;
  int  toggles[$];
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_col actual=%h expected=none (cycle %0d)", out_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("col_data", out_data, e.data);
        chk("col_first", 64'(out_first), 64'(e.first));
        chk("col_last", 64'(out_last), 64'(e.last));
      end
      if (!out_first) chk("col_gap", 64'(prev_ov), 64'd1);
      if (out_first) first_out_cyc = cyc;
      ncols++;
    end
    prev_ov = out_valid;
    if (ram_rnw !== prev_rnw) toggles.push_back(cyc);
    prev_rnw = ram_rnw;
  end

  int last_acc_cyc = 0;
  int blk_start_cyc = 0;

  task automatic send_row(input logic [63:0] d, input int r);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        last_acc_cyc = cyc;
        chk("wr_wa", 64'(ram_wa), 64'(r));
        chk("wr_be", 64'(ram_be), 64'hFF);
        chk("wr_dv", 64'(ram_din_valid), 64'd1);
        chk("wr_di", ram_di, d);
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept expected=accept row=%0d", r);
    end
  endtask

  task automatic send_block(input int kind, input int b, input bit gaps);
    for (int r = 0; r < 8; r++) begin
      send_row(row_word(kind, b, r), r);
      if (r == 0) blk_start_cyc = last_acc_cyc;
      if (gaps && r < 7) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("gap_dv", 64'(ram_din_valid), 64'd0);
        chk("gap_be", 64'(ram_be), 64'd0);
        @(posedge clk); #1;
      end
    end
    for (int c = 0; c < 8; c++) sb.push_back('{col_word(kind, b, c), c == 0, c == 7});
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending columns", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    // Reset held 3 cycles with in_valid high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_rnw", 64'(ram_rnw), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_dv", 64'(ram_din_valid), 64'd0);
      chk("rst_be", 64'(ram_be), 64'd0);
      chk("rst_wa", 64'(ram_wa), 64'd0);
      chk("rst_ra", 64'(ram_ra), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Single block, back-to-back rows.
    toggles.delete();
    ncols = 0;
    send_block(0, 0, 1'b0);
    s = last_acc_cyc;
    drain();
    chk("single_latency", 64'(first_out_cyc - s), 64'd4);
    chk("single_ncols", 64'(ncols), 64'd8);
    chk("single_rnw", 64'(ram_rnw), 64'd0);
    chk("single_toggles", 64'(toggles.size()), 64'd1);

    // Four blocks streamed continuously.
    toggles.delete();
    ncols = 0;
    send_block(1, 0, 1'b0);
    s = blk_start_cyc;
    for (int b = 1; b < 4; b++) send_block(1, b, 1'b0);
    chk("stream_accept_span", 64'(last_acc_cyc - s), 64'd34);
    drain();
    chk("stream_ncols", 64'(ncols), 64'd32);
    chk("stream_toggles", 64'(toggles.size()), 64'd4);
    for (int i = 1; i < toggles.size(); i++)
      chk("stream_toggle_period", 64'(toggles[i] - toggles[i-1]), 64'd9);

    // Input gaps: in_valid alternating.
    ncols = 0;
    send_block(0, 0, 1'b1);
    drain();
    chk("gap_ncols", 64'(ncols), 64'd8);

    // Reset while block 0 drains and block 1 is partially written.
    send_block(1, 1, 1'b0);
    for (int r = 0; r < 5; r++) send_row(row_word(1, 2, r), r);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_discarded", 64'(sb.size()), 64'd4);
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_rnw", 64'(ram_rnw), 64'd1);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    ncols = 0;
    send_block(1, 3, 1'b0);
    drain();
    chk("post_rst_ncols", 64'(ncols), 64'd8);
    chk("post_rst_rnw", 64'(ram_rnw), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dualram_seq.md
# dualram_seq

Sequencer that drives the `dualram` ping-pong transpose memory in the DCTQ datapath. It accepts 64-bit row words from the row-wise 1-D DCT stage through a valid/ready handshake and generates the write side: `wa`, `be`, `din_valid` and `di`. It owns bank switching through `rnw` and issues column read addresses `ra`. It re-times `dualram`'s `do` into a valid-qualified column stream for the column-wise DCT/quantizer stage.

## Interface
Parameters:
- `ROWS`, 8: rows/columns per block. Equals dualram depth. `wa`/`ra` width is clog2(ROWS) = 3.
- `RD_LAT`, 2: cycles from `ram_ra` presented to matching `ram_do` valid. This is the ram_rc read register plus the dualram output register.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock (all logic on posedge)
- `rst`  in  1  synchronous active-high reset
- `in_valid`  in  1  row word available
- `in_ready`  out  1  sequencer accepts a row this cycle
- `in_data`  in  64  row word (8 coefficients × 8 bit)
- `ram_di`  out  64  to dualram `di`; equals `in_data` (combinational)
- `ram_din_valid`  out  1  to dualram `din_valid`; `in_valid & in_ready`
- `ram_be`  out  8  to dualram `be`; 8'hFF when `ram_din_valid`, else 8'h00
- `ram_wa`  out  3  to dualram `wa`; current write row
- `ram_ra`  out  3  to dualram `ra`; current read column
- `ram_rnw`  out  1  to dualram `rnw`; bank select (1: ram1 written, ram2 read)
- `ram_do`  in  64  from dualram `do`
- `out_valid`  out  1  `out_data` holds a column word
- `out_data`  out  64  equals `ram_do`
- `out_first`  out  1  with `out_valid`: column 0 of a block
- `out_last`  out  1  with `out_valid`: column ROWS-1 of a block

## Operation
- **Write FSM states**
  - WFILL: `in_ready`=1. Each accepted row writes at `ram_wa`=`wcnt`, then `wcnt`++. Accepting with `wcnt`=ROWS-1 moves to WFULL and wraps `wcnt` to 0. If `in_valid`=0, `wcnt` holds.
  - WFULL: `in_ready`=0; wait for swap.
- **Read FSM states**
  - RIDLE: no reads issued.
  - RDRAIN: issues `ram_ra`=`rcnt`, `rcnt`++ every cycle with no stall. The issue with `rcnt`=ROWS-1 returns to RIDLE and wraps `rcnt` to 0.
- **Swap**: in any cycle with WFULL and RIDLE, toggle `ram_rnw` at the clock edge. Write goes to WFILL and read goes to RDRAIN.
  - The swap cycle is a one-cycle write bubble.
  - A block is never read before a swap, and a bank is never rewritten before it is fully drained.
- **Read tracking**: an RD_LAT-deep shift register carries {issue, first, last} per read issue. Its output drives `out_valid`, `out_first` and `out_last`.
- Downstream must accept every `out_valid` cycle; there is no output backpressure.
- **Reset values**: `in_ready`=0 during `rst`; `ram_rnw`=1, `ram_wa`=0, `ram_ra`=0; `ram_be`=0, `ram_din_valid`=0; `out_valid`/`out_first`/`out_last`=0; FSMs in WFILL/RIDLE; counters 0; delay line cleared.
- **Reset mid-block**: partial write and read blocks are discarded. `out_valid` is 0 from the cycle after `rst` is sampled, even for reads already in flight. Memory contents are not cleared and are overwritten by the next block.

## Timing
- The last row is accepted at edge E, which ends cycle t.
  - Cycle t+1: WFULL; swap at its end (RIDLE assumed).
  - Cycle t+2: `ram_ra`=0 and `in_ready`=1.
  - Cycle t+2+RD_LAT = t+4: first `out_valid` with `out_first`=1.
  - Cycle t+11: `out_last`.
- Steady state with continuous `in_valid`: block period is ROWS+1 = 9 cycles. `in_ready` is low exactly one cycle per block. Reads of block n overlap writes of block n+1.
- If read is still draining when write becomes full, stay in WFULL until RIDLE. The swap occurs in the first cycle where both hold.
- `in_ready` depends only on state, never combinationally on `in_valid`.

## Structure
- Shared package `dctq_pkg`:
  - constants `DCTQ_ROWS`=8, `DCTQ_WORD_W`=64, `DCTQ_ADDR_W`=3
  - enums `wr_state_t` {WFILL, WFULL} and `rd_state_t` {RIDLE, RDRAIN}
- One sub-module, `rd_valid_pipe`: a parameterised RD_LAT-stage, 3-bit sync-reset delay line for the issue/first/last flags.
- `dualram` itself is instantiated by the parent, not inside this block.

## Test plan
- **Reset**: hold `rst` 3 cycles with `in_valid`=1 → `in_ready`=0, `ram_rnw`=1, `out_valid`=0 throughout. Release → `in_ready`=1 the next cycle.
- **Single block**: rows r with `in_data`=64'h0101…×r, r=0..7, back-to-back.
  - Writes: `ram_wa` 0..7, `ram_be`=FF.
  - Swap: `ram_rnw` 1→0 once.
  - Output: 8 `out_valid` words starting 4 cycles after the last accept. Each column word equals bytes {0,1,…,7}; `out_first`/`out_last` on columns 0/7.
- **Streaming**: 4 blocks continuous → `in_ready` low exactly 1 cycle per 9, `ram_rnw` toggles every 9 cycles, 32 columns out with no gaps within a block.
- **Input gaps**: `in_valid` toggling 1/0 → `wcnt` holds on 0 cycles, `ram_din_valid`=0 and `ram_be`=0 there, output data unchanged vs. scenario 2.
- **Mid-block reset**: assert `rst` after 5 rows of block 1 while block 0 is draining at column 3 → `out_valid`=0 from the next cycle. A following full block outputs correctly with `ram_rnw` restarting at 1.
